instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the single-cycle control/datapath. Owns the PC, fetches instruction
//  words from instruction memory over a req/ready handshake, and holds each word in an
//  instruction register. Presents Opcode/FuncCode to the control decoder.
//  Resolves next-PC from the Branch, Jump and Zero signals returned by control/ALU.
// PARAMETERS
//  PC_RESET   32'h0000_0000  PC value loaded on Reset
//  CNT_W      32             width of retired-instruction counter
// PORTS
//  CLK           in   1      clock; all state updates on the rising edge
//  Reset         in   1      synchronous, active-high reset
//  imem_req      out  1      fetch request to instruction memory
//  imem_addr     out  32     word address of the fetch (= PC)
//  imem_ready    in   1      imem_rdata valid this cycle; completes the request
//  imem_rdata    in   32     fetched instruction word
//  Instruction   out  32     instruction register (IR)
//  Opcode        out  6      IR[31:26]
//  FuncCode      out  6      IR[5:0]
//  InstrValid    out  1      IR holds an instruction for downstream
//  PCPlus4       out  32     PC+4 of the instruction in IR
//  Stall         in   1      downstream hold; IR is not consumed while high
//  Branch        in   1      from control: IR is BEQ
//  Jump          in   1      from control: IR is J
//  Zero          in   1      from ALU: equality result for BEQ
//  InstrCount    out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset values: PC=PC_RESET, state=FETCH, IR=0, InstrValid=0, InstrCount=0,
//    imem_req=0 during the Reset cycle, delay-slot pending flag=0.
//  - FSM states:
//    - FETCH
//      - imem_req=1 and imem_addr=PC, both stable until imem_ready.
//      - On imem_ready: IR<=imem_rdata, go ISSUE.
//    - ISSUE
//      - InstrValid=1 and imem_req=0.
//      - Retire condition: Stall==0. On retire: PC<=NextPC, InstrCount+=1, go FETCH.
//      - While Stall==1: IR and PC hold.
//  - Latency: min 2 cycles/instruction (1 FETCH with same-cycle ready + 1 ISSUE).
//  - NextPC:
//    - Jump=1: {PCPlus4[31:28], IR[25:0], 2'b00}. Jump has priority over Branch.
//    - Branch&Zero: PCPlus4 + (sign-extended IR[15:0] << 2), 32-bit wraparound.
//    - Otherwise: PCPlus4.
//  - Branch, Jump and Zero are sampled only in the retire cycle; ignored elsewhere.
//  - PC wrap: 32'hFFFF_FFFC + 4 -> 0; no fault is raised.
//  - Reset mid-request:
//    - The outstanding fetch is abandoned.
//    - An imem_ready in the Reset cycle is ignored.
//    - imem_req is 0 in the Reset cycle and reasserts with PC_RESET on the next cycle.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined:
//    - On retire of a taken branch or jump: target is saved to PendTarget, pending=1,
//      PC<=PCPlus4.
//    - The next retire goes to PendTarget and clears pending. Branch/Jump/Zero are
//      ignored on that retire (control transfer in a delay slot is not honoured).
//  Not defined: NextPC is applied immediately, as above. No PendTarget register exists.
// STRUCTURE
//  - Shared package mips_defs_pkg: opcode/funct constants (R-type, LW, SW, BEQ, J,
//    immediates) and FSM state encoding, shared with the control decoder.
//  - Sub-module next_pc_calc: combinational; (PCPlus4, IR, Branch, Jump, Zero) -> NextPC.
//  - FSM, PC, IR and counter stay in the top module.
// TESTING
//  - Reset: Reset=1 for 2 cycles, then release -> next cycle imem_req=1, imem_addr=0,
//    InstrValid=0, InstrCount=0.
//  - Sequential: memory always ready, words at 0/4/8 are ADD -> imem_addr 0,4,8 on
//    alternate cycles; InstrCount=3 after the third ISSUE.
//  - Taken BEQ: at PC 0x8, imm=3, Branch=1, Zero=1 -> next imem_addr=0x18.
//    Same case with Zero=0 -> next imem_addr=0xC.
//  - Jump: word 0x0800_0010 at PC 0x1C, Jump=1 -> next imem_addr=0x40.
//  - Stall/wait: imem_ready delayed 3 cycles -> imem_addr stable throughout.
//    Stall=1 for 4 cycles in ISSUE -> IR, PC and InstrCount unchanged.
//    Then assert Reset mid-FETCH -> following cycle imem_addr=PC_RESET.
//  - BRANCH_DELAY_SLOT_EN: taken BEQ at 0x8 -> fetches 0xC, then 0x18.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encoding constants and fetch FSM state type, common to the fetch unit and
// the control decoder.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_t;

    // Byte offset of a BEQ: sign-extended word immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC resolution for the instruction held in IR.
// Jump has priority over a taken branch; otherwise fall through to PC+4.
module next_pc_calc
    import mips_defs_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_index, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(instr_index[15:0]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC, instruction register and fetch/issue FSM for the single-cycle datapath.
// Optional build macro BRANCH_DELAY_SLOT_EN defers taken control transfers by one instruction.
module instr_fetch_unit
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Instruction,
    output logic [5:0]       Opcode,
    output logic [5:0]       FuncCode,
    output logic             InstrValid,
    output logic [31:0]      PCPlus4,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    output logic [CNT_W-1:0] InstrCount
);

    fetch_state_t     state_reg, state_next;
    logic [31:0]      pc_reg;
    logic [31:0]      ir_reg;
    logic [CNT_W-1:0] count_reg;
    logic             retire;
    logic [31:0]      pc_plus4;
    logic [31:0]      calc_pc;
    logic [31:0]      retire_pc;

    assign pc_plus4    = pc_reg + 32'd4;
    assign imem_addr   = pc_reg;
    assign Instruction = ir_reg;
    assign Opcode      = ir_reg[31:26];
    assign FuncCode    = ir_reg[5:0];
    assign PCPlus4     = pc_plus4;
    assign InstrValid  = (state_reg == ST_ISSUE);
    assign InstrCount  = count_reg;

    next_pc_calc u_next_pc (
        .pc_plus4    (pc_plus4),
        .instr_index (ir_reg[25:0]),
        .branch      (Branch),
        .jump        (Jump),
        .zero        (Zero),
        .next_pc     (calc_pc)
    );

    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                // Request drops in the reset cycle so an abandoned fetch is not re-sent.
                imem_req = !Reset;
                if (imem_ready) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!Stall) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_reg;
    logic [31:0] pend_target_reg;
    logic        taken;

    assign taken = Jump || (Branch && Zero);
    // A pending transfer wins; control signals of the delay-slot instruction are ignored.
    assign retire_pc = pend_reg ? pend_target_reg : pc_plus4;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend_reg        <= 1'b0;
            pend_target_reg <= 32'd0;
        end else if (retire) begin
            if (pend_reg) begin
                pend_reg <= 1'b0;
            end else if (taken) begin
                pend_reg        <= 1'b1;
                pend_target_reg <= calc_pc;
            end
        end
    end
`else
    assign retire_pc = calc_pc;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= PC_RESET;
            ir_reg    <= 32'd0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH && imem_ready) ir_reg <= imem_rdata;
            if (retire) begin
                pc_reg    <= retire_pc;
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level PC model.
// Honours BRANCH_DELAY_SLOT_EN when the design is built with it.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [5:0]  FuncCode;
    logic        InstrValid;
    logic [31:0] PCPlus4;
    logic        Stall;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] InstrCount;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_pend;
    logic [31:0] m_target;

    localparam logic [31:0] W_ADD = 32'h0022_1820;
    localparam logic [31:0] W_J40 = 32'h0800_0010;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.PC_RESET(32'h0000_0000), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .Instruction(Instruction),
        .Opcode(Opcode), .FuncCode(FuncCode), .InstrValid(InstrValid), .PCPlus4(PCPlus4),
        .Stall(Stall), .Branch(Branch), .Jump(Jump), .Zero(Zero), .InstrCount(InstrCount)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    function automatic logic [31:0] beq_word(input logic [15:0] imm);
        return {6'h04, 5'd1, 5'd2, imm};
    endfunction

    task automatic noise();
        Branch = 1'($urandom);
        Jump   = 1'($urandom);
        Zero   = 1'($urandom);
    endtask

    // Architectural effect of one retired instruction.
    task automatic model_retire(input logic [31:0] word, input logic br, input logic jp, input logic z);
        logic [31:0] pc4, tgt;
        shortint     s;
        logic        taken;
        pc4   = m_pc + 32'd4;
        s     = shortint'(word[15:0]);
        taken = jp || (br && z);
        if (jp)              tgt = (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        else if (br && z)    tgt = pc4 + 32'(int'(s) * 4);
        else                 tgt = pc4;
        if (DS) begin
            if (m_pend) begin
                m_pc   = m_target;
                m_pend = 1'b0;
            end else if (taken) begin
                m_target = tgt;
                m_pend   = 1'b1;
                m_pc     = pc4;
            end else begin
                m_pc = pc4;
            end
        end else begin
            m_pc = tgt;
        end
        m_count = m_count + 32'd1;
    endtask

    task automatic do_reset(input logic ready_during);
        Reset      = 1'b1;
        imem_ready = ready_during;
        imem_rdata = $urandom;
        Stall      = 1'b0;
        noise();
        @(negedge CLK);
        check_val("rst_req_low", 32'(imem_req), 32'd0);
        Reset      = 1'b0;
        imem_ready = 1'b0;
        @(negedge CLK);
        m_pc = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_target = 32'd0;
        $display("reset (ready=%0b): req=%0b addr=%h valid=%0b count=%0d ir=%h",
                 ready_during, imem_req, imem_addr, InstrValid, InstrCount, Instruction);
        check_val("rst_req", 32'(imem_req), 32'd1);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_valid", 32'(InstrValid), 32'd0);
        check_val("rst_count", InstrCount, 32'd0);
        check_val("rst_ir", Instruction, 32'd0);
    endtask

    // One fetch/issue/retire transaction; entered and left at a negedge in FETCH.
    task automatic run_instr(input logic [31:0] word, input int delay, input int stalls,
                             input logic br, input logic jp, input logic z);
        logic [31:0] pc_at;
        pc_at = m_pc;
        check_val("fetch_req", 32'(imem_req), 32'd1);
        check_val("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            noise();
            @(negedge CLK);
            check_val("addr_hold", imem_addr, m_pc);
            check_val("req_hold", 32'(imem_req), 32'd1);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        noise();
        @(negedge CLK);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check_val("issue_valid", 32'(InstrValid), 32'd1);
        check_val("issue_req", 32'(imem_req), 32'd0);
        check_val("issue_ir", Instruction, word);
        check_val("issue_op", 32'(Opcode), word >> 26);
        check_val("issue_fn", 32'(FuncCode), word & 32'h3F);
        check_val("issue_pc4", PCPlus4, pc_at + 32'd4);
        for (int i = 0; i < stalls; i++) begin
            Stall = 1'b1;
            noise();
            @(negedge CLK);
            check_val("stall_ir", Instruction, word);
            check_val("stall_pc4", PCPlus4, pc_at + 32'd4);
            check_val("stall_count", InstrCount, m_count);
            check_val("stall_valid", 32'(InstrValid), 32'd1);
        end
        Stall  = 1'b0;
        Branch = br;
        Jump   = jp;
        Zero   = z;
        @(negedge CLK);
        noise();
        model_retire(word, br, jp, z);
        $display("instr pc=%h word=%h dly=%0d stl=%0d br=%0b j=%0b z=%0b -> addr=%h count=%0d",
                 pc_at, word, delay, stalls, br, jp, z, imem_addr, InstrCount);
        check_val("retire_valid", 32'(InstrValid), 32'd0);
        check_val("retire_count", InstrCount, m_count);
        check_val("next_addr", imem_addr, m_pc);
    endtask

    initial begin
        Reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; Stall = 1'b0;
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        m_pc = 32'd0; m_count = 32'd0; m_pend = 1'b0; m_target = 32'd0;

        // Reset held two cycles
        @(negedge CLK);
        check_val("rst1_req_low", 32'(imem_req), 32'd0);
        do_reset(1'b0);

        // Sequential ADDs, then a taken BEQ at 0x8
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        check_val("seq_addr8", imem_addr, 32'h8);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        check_val("seq_count3", InstrCount, 32'd3);

        do_reset(1'b0);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(beq_word(16'd3), 0, 0, 1'b1, 1'b0, 1'b1);
        check_val("beq_taken", imem_addr, DS ? 32'hC : 32'h18);
        if (DS) begin
            run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
            check_val("beq_ds_target", imem_addr, 32'h18);
        end
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(W_J40, 0, 0, 1'b0, 1'b1, 1'b0);
        if (DS) run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        check_val("jump_target", imem_addr, 32'h40);

        // Not-taken BEQ
        do_reset(1'b0);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(beq_word(16'd3), 0, 0, 1'b1, 1'b0, 1'b0);
        check_val("beq_not_taken", imem_addr, 32'hC);

        // Slow memory and downstream stall, then reset in the middle of a fetch
        run_instr(W_ADD, 3, 4, 1'b0, 1'b0, 1'b0);
        run_instr(W_ADD, 2, 0, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);

        // PC wraps from 0xFFFF_FFFC to 0
        run_instr(beq_word(16'hFFFE), 0, 0, 1'b1, 1'b0, 1'b1);
        if (DS) run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        check_val("wrap_top", imem_addr, 32'hFFFF_FFFC);
        run_instr(W_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        check_val("wrap_zero", imem_addr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 39) == 0) begin
                do_reset(1'($urandom));
            end
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
